// File: rtl/iso7816_char_tx.sv
// ISO 7816-3 character transmitter: start bit, 8 data bits, parity, guard time,
// with error-signal sampling and bounded retransmission on an open-drain line.
module iso7816_char_tx (
   input  logic       clk,
   input  logic       nReset,
   input  logic       etuTick,
   input  logic       inverseConvention,
   input  logic [7:0] guardEtus,
   input  logic [2:0] maxRetries,
   input  logic [7:0] dataIn,
   input  logic       startTx,
   input  logic       ioIn,
   output logic       ioDriveLow,
   output logic       ready,
   output logic       done,
   output logic       error,
   output logic [2:0] retryCount
);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_BITS, S_GUARD} state_t;

   state_t     state, state_nxt;
   logic [3:0] bit_idx;
   logic [8:0] guard_cnt;
   logic [7:0] data_q;
   logic [7:0] guard_q;
   logic       inv_q;
   logic [2:0] max_q;
   logic [2:0] retry_q;
   logic       err_flag;

   logic       last_bit;
   logic       guard_end;
   logic       retry_ok;
   logic       drive_nxt;
   logic       done_nxt;
   logic       error_nxt;
   logic       ready_nxt;

   // Line level of frame position idx (0 = start, 1..8 = data, 9 = parity).
   function automatic logic bit_level(input logic [3:0] idx, input logic [7:0] data,
                                      input logic inv);
      logic [2:0] k;
      logic       lvl;
      k = inv ? (3'd0 - idx[2:0]) : (idx[2:0] - 3'd1);
      if (idx == 4'd0)
         lvl = 1'b0;
      else if (idx == 4'd9)
         lvl = inv ? ~(^data) : (^data);
      else
         lvl = inv ? ~data[k] : data[k];
      return lvl;
   endfunction

   assign last_bit   = (bit_idx == 4'd9);
   // Guard lasts 2+guardEtus ticks; the counter holds ticks already seen in guard.
   assign guard_end  = (state == S_GUARD) && etuTick &&
                       (guard_cnt == ({1'b0, guard_q} + 9'd1));
   assign retry_ok   = (retry_q < max_q);
   assign retryCount = retry_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (startTx) state_nxt = S_ARM;
         S_ARM:   if (etuTick) state_nxt = S_BITS;
         S_BITS:  if (etuTick && last_bit) state_nxt = S_GUARD;
         S_GUARD: begin
            if (guard_end)
               state_nxt = (err_flag && retry_ok) ? S_ARM : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: every output gets a default first, so no latch can be inferred.
   always_comb begin
      drive_nxt = 1'b0;
      case (state)
         S_ARM:  drive_nxt = etuTick;
         S_BITS: begin
            if (!etuTick)
               drive_nxt = ioDriveLow;
            else if (!last_bit)
               drive_nxt = ~bit_level(bit_idx + 4'd1, data_q, inv_q);
         end
         default: drive_nxt = 1'b0;
      endcase
      done_nxt  = guard_end && !err_flag;
      error_nxt = guard_end && err_flag && !retry_ok;
      ready_nxt = (state_nxt == S_IDLE);
   end

   // NOTE: latched character settings are reset too, so nothing ever reads an X after reset.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         bit_idx    <= 4'd0;
         guard_cnt  <= 9'd0;
         data_q     <= 8'd0;
         guard_q    <= 8'd0;
         inv_q      <= 1'b0;
         max_q      <= 3'd0;
         retry_q    <= 3'd0;
         err_flag   <= 1'b0;
         ioDriveLow <= 1'b0;
         ready      <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         ioDriveLow <= drive_nxt;
         ready      <= ready_nxt;
         done       <= done_nxt;
         error      <= error_nxt;
         case (state)
            S_IDLE: begin
               if (startTx) begin
                  data_q   <= dataIn;
                  inv_q    <= inverseConvention;
                  guard_q  <= guardEtus;
                  max_q    <= maxRetries;
                  retry_q  <= 3'd0;
                  err_flag <= 1'b0;
               end
            end
            S_ARM: begin
               if (etuTick) bit_idx <= 4'd0;
            end
            S_BITS: begin
               if (etuTick) begin
                  bit_idx   <= bit_idx + 4'd1;
                  guard_cnt <= 9'd0;
               end
            end
            S_GUARD: begin
               if (etuTick) begin
                  guard_cnt <= guard_cnt + 9'd1;
                  if ((guard_cnt == 9'd0) && !ioIn)
                     err_flag <= 1'b1;
                  if (guard_end && err_flag && retry_ok) begin
                     retry_q  <= retry_q + 3'd1;
                     err_flag <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iso7816_char_tx.sv
// Randomized bench for iso7816_char_tx: per-ETU line levels, pulses and retry
// counts are compared against a frame-level reference model.
module tb_iso7816_char_tx;

   logic       clk = 1'b0;
   logic       nReset;
   logic       etu_tick;
   logic       inverse_convention;
   logic [7:0] guard_etus;
   logic [2:0] max_retries;
   logic [7:0] data_in;
   logic       start_tx;
   logic       io_in;
   logic       io_drive_low;
   logic       ready;
   logic       done;
   logic       error;
   logic [2:0] retry_count;

   always #5 clk = ~clk;

   iso7816_char_tx dut (
      .clk               (clk),
      .nReset            (nReset),
      .etuTick           (etu_tick),
      .inverseConvention (inverse_convention),
      .guardEtus         (guard_etus),
      .maxRetries        (max_retries),
      .dataIn            (data_in),
      .startTx           (start_tx),
      .ioIn              (io_in),
      .ioDriveLow        (io_drive_low),
      .ready             (ready),
      .done              (done),
      .error             (error),
      .retryCount        (retry_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Free-running ETU tick generator, period etu_clks cycles.
   int etu_clks = 4;
   int ph = 0;
   initial begin
      etu_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ph >= etu_clks - 1) begin
            ph = 0;
            etu_tick = 1'b1;
         end else begin
            ph++;
            etu_tick = 1'b0;
         end
      end
   end

   int cyc = 0;
   int tick_n = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (etu_tick) tick_n <= tick_n + 1;

   // Line level of the ETU that ends at each tick.
   bit drv_log[$];
   int last_tick_cyc = 0;
   always @(negedge clk) begin
      if (etu_tick) begin
         drv_log.push_back(io_drive_low);
         last_tick_cyc = cyc;
      end
   end

   // Card model: follows the line, optionally signals error at boundary 11
   // of chosen attempts, optionally pulls low late in guard (must be ignored).
   logic       active = 1'b0;
   logic [7:0] inj_mask = 8'h00;
   bit         noise = 1'b0;
   int         per = 13;
   int         tick_base = 0;
   always_comb begin
      int         idx;
      logic [2:0] att;
      io_in = ~io_drive_low;
      idx   = tick_n - tick_base;
      att   = 3'(idx / per);
      if (active && etu_tick && idx >= 0) begin
         if ((idx % per) == 11 && (idx / per) < 8 && inj_mask[att]) io_in = 1'b0;
         if (noise && (idx % per) >= 12) io_in = 1'b0;
      end
   end

   task automatic run_char(input logic [7:0] d, input logic inv, input logic [7:0] g,
                           input logic [2:0] mr, input logic [7:0] mask, input bit nz,
                           input bit align, input bit at_neg, input bit poke, input bit chain,
                           output logic [9:0] frame);
      int         a;
      int         attempts;
      int         base_log;
      int         bound;
      int         n_done;
      int         n_err;
      int         wait_c;
      int         mism;
      bit         exp_err;
      bit         exp_q[$];
      logic [7:0] e;
      logic       p;

      // Reference: how many attempts, and the drive level of every ETU.
      a = 0;
      while (mask[3'(a)] && a < int'(mr)) a++;
      exp_err  = mask[3'(a)];
      attempts = a + 1;
      for (int k = 0; k < 8; k++) e[k] = inv ? ~d[7-k] : d[k];
      p = inv ? ~(^d) : (^d);
      for (int t = 0; t < attempts; t++) begin
         exp_q.push_back(1'b0);
         exp_q.push_back(1'b1);
         for (int k = 0; k < 8; k++) exp_q.push_back(~e[k]);
         exp_q.push_back(~p);
         for (int k = 0; k < 2 + int'(g); k++) exp_q.push_back(1'b0);
      end

      if (!at_neg) begin
         @(posedge clk); #2;
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
         if (align)
            for (int w = 0; w < 20 && !etu_tick; w++) begin @(posedge clk); #2; end
      end
      data_in = d; inverse_convention = inv; guard_etus = g; max_retries = mr;
      inj_mask = mask; noise = nz; per = 13 + int'(g);
      start_tx = 1'b1;
      @(posedge clk); #2;
      start_tx = 1'b0;
      check("ready_fall", {31'd0, ready}, 32'd0);
      tick_base = tick_n;
      base_log  = drv_log.size();
      active    = 1'b1;
      data_in = 8'($urandom); guard_etus = 8'($urandom);
      max_retries = 3'($urandom); inverse_convention = 1'($urandom);

      bound  = attempts * (per + 1) * etu_clks + 40;
      n_done = 0; n_err = 0; wait_c = 0;
      while (n_done + n_err == 0 && wait_c < bound) begin
         @(negedge clk);
         wait_c++;
         start_tx = (poke && wait_c == 17);
         n_done += int'(done);
         n_err  += int'(error);
      end
      start_tx = 1'b0;

      check("pulse_seen", n_done + n_err, 1);
      check("done_pulse", n_done, {31'd0, !exp_err});
      check("error_pulse", n_err, {31'd0, exp_err});
      check("retry_count", {29'd0, retry_count}, a);
      check("ready_rise", {31'd0, ready}, 32'd1);
      check("pulse_timing", cyc, last_tick_cyc + 1);
      check("etu_count", drv_log.size() - base_log, exp_q.size());
      mism = 0;
      foreach (exp_q[i])
         if (base_log + i >= drv_log.size() || drv_log[base_log + i] !== exp_q[i]) mism++;
      check("etu_levels", mism, 0);
      frame = 'x;
      for (int k = 0; k < 10; k++)
         if (base_log + 1 + k < drv_log.size()) frame[9-k] = drv_log[base_log + 1 + k];
      active = 1'b0;
      if (!chain) repeat (3) @(posedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got no end expected end");
      $fatal(1);
   end

   logic [9:0] frame;
   bit         prev_chain;
   int         pulses;
   int         drives;

   initial begin
      nReset = 1'b0; start_tx = 1'b0; data_in = 8'h00; inverse_convention = 1'b0;
      guard_etus = 8'h00; max_retries = 3'd0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_drive", {31'd0, io_drive_low}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_retry", {29'd0, retry_count}, 32'd0);
      nReset = 1'b1;
      repeat (5) @(posedge clk);

      // Directed frames.
      run_char(8'h3B, 1'b0, 8'd0, 3'd0, 8'h00, 0, 0, 0, 0, 0, frame);
      check("frame_3b_direct", {22'd0, frame}, {22'd0, 10'b1001000110});
      run_char(8'h3F, 1'b1, 8'd0, 3'd0, 8'h00, 0, 0, 0, 0, 0, frame);
      check("frame_3f_inverse", {22'd0, frame}, {22'd0, 10'b1001111110});
      run_char(8'hA5, 1'b0, 8'd0, 3'd2, 8'h01, 1, 0, 0, 0, 0, frame);  // retry, then ok
      run_char(8'h5A, 1'b1, 8'd0, 3'd1, 8'hFF, 0, 0, 0, 0, 0, frame);  // retries exhausted
      run_char(8'hC3, 1'b0, 8'd0, 3'd7, 8'hFF, 0, 0, 0, 0, 0, frame);  // saturate at 7
      run_char(8'h81, 1'b0, 8'd5, 3'd0, 8'h00, 1, 0, 0, 0, 0, frame);  // 17-ETU character
      run_char(8'h12, 1'b0, 8'd1, 3'd0, 8'h00, 0, 1, 0, 1, 1, frame);  // tick-aligned, poke, chain
      run_char(8'h34, 1'b1, 8'd2, 3'd3, 8'h02, 0, 0, 1, 0, 0, frame);  // started in done cycle
      etu_clks = 2;
      run_char(8'hE7, 1'b0, 8'd255, 3'd0, 8'h00, 0, 0, 0, 0, 0, frame); // longest guard

      prev_chain = 0;
      for (int n = 0; n < 20; n++) begin
         logic [7:0] m;
         bit         ch;
         if (!prev_chain) etu_clks = $urandom_range(2, 5);
         m  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom & $urandom);
         ch = ($urandom_range(0, 2) == 0);
         run_char(8'($urandom), 1'($urandom), 8'($urandom_range(0, 12)),
                  3'($urandom_range(0, 7)), m, 1'($urandom), 1'($urandom), prev_chain,
                  1'($urandom), ch, frame);
         prev_chain = ch;
      end
      if (prev_chain) repeat (3) @(posedge clk);

      // Reset in the middle of the data bits.
      etu_clks = 4;
      @(posedge clk); #2;
      data_in = 8'h00; inverse_convention = 1'b0; guard_etus = 8'd0; max_retries = 3'd0;
      start_tx = 1'b1;
      @(posedge clk); #2;
      start_tx = 1'b0;
      tick_base = drv_log.size();
      for (int w = 0; w < 200 && drv_log.size() < tick_base + 6; w++) @(posedge clk);
      @(posedge clk); #3;
      check("pre_reset_drive", {31'd0, io_drive_low}, 32'd1);
      nReset = 1'b0;
      #1;
      check("async_release", {31'd0, io_drive_low}, 32'd0);
      check("async_ready", {31'd0, ready}, 32'd1);
      @(negedge clk);
      nReset = 1'b1;
      pulses = 0; drives = 0;
      repeat (80) begin
         @(negedge clk);
         pulses += int'(done) + int'(error);
         drives += int'(io_drive_low);
      end
      check("no_pulse_after_reset", pulses, 0);
      check("idle_released", drives, 0);
      check("idle_ready", {31'd0, ready}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
